serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 11 +
 rtl/serial_subtractor_if.sv | 36 +++
 rtl/_and2.sv | 9 +
 rtl/_inv.sv | 8 +
 rtl/_or2.sv | 9 +
 rtl/_xor2.sv | 9 +
 rtl/serial_subtractor_fs1.sv | 26 ++
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 9 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding for the bit-serial subtractor
// Contents: state_t FSM encoding (IDLE/RUN/DONE).
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bundle
// Signals: start, a, b (toward the subtractor); busy, done, d, borrow_out (from it).
// Optional: ovf when SERIAL_SUBTRACTOR_OVF_EN is defined.
// Modports: master (controller side), slave (subtractor side).
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
    input  busy, done, d, borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b,
    output busy, done, d, borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/_and2.sv
// rtl/_and2.sv - two-input AND gate primitive
// Ports: a, b (in), y (out) = a & b.
module _and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/_inv.sv
// rtl/_inv.sv - inverter gate primitive
// Ports: a (in), y (out) = ~a.
module _inv (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

// File: rtl/_or2.sv
// rtl/_or2.sv - two-input OR gate primitive
// Ports: a, b (in), y (out) = a | b.
module _or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

// File: rtl/_xor2.sv
// rtl/_xor2.sv - two-input XOR gate primitive
// Ports: a, b (in), y (out) = a ^ b.
module _xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/serial_subtractor_fs1.sv
// rtl/serial_subtractor_fs1.sv - one-bit full subtractor built from gate primitives
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in) -> diff, bout (borrow out).
// diff = a ^ b ^ bin ; bout = (~a & b) | (~(a ^ b) & bin)
module serial_subtractor_fs1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic axb;
  logic na;
  logic naxb;
  logic t_ab;
  logic t_bin;

  _xor2 u_xor_ab   (.a(a),     .b(b),     .y(axb));
  _xor2 u_xor_diff (.a(axb),   .b(bin),   .y(diff));
  _inv  u_inv_a    (.a(a),                .y(na));
  _inv  u_inv_axb  (.a(axb),              .y(naxb));
  _and2 u_and_ab   (.a(na),    .b(b),     .y(t_ab));
  _and2 u_and_bin  (.a(naxb),  .b(bin),   .y(t_bin));
  _or2  u_or_bout  (.a(t_ab),  .b(t_bin), .y(bout));

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor d = a - b, LSB first
// Ports: clk, reset (sync, active-high), bus (serial_subtractor_if.slave:
//   start/a/b in; busy/done/d/borrow_out out).
// Optional: SERIAL_SUBTRACTOR_OVF_EN adds bus.ovf (signed overflow, valid with done).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_subtractor_if.slave     bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             busy_c;
  logic             done_c;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_r;
  logic             borrow;
  logic             borrow_out_r;
  logic [CW-1:0]    cnt;
  logic             diff;
  logic             bout;

  serial_subtractor_fs1 u_fs1 (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .diff (diff),
    .bout (bout)
  );

  // Bit WIDTH-1 is being processed this cycle.
  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_c = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh         <= '0;
      b_sh         <= '0;
      d_r          <= '0;
      borrow       <= 1'b0;
      borrow_out_r <= 1'b0;
      cnt          <= '0;
    end else if (accept) begin
      a_sh         <= bus.a;
      b_sh         <= bus.b;
      d_r          <= '0;
      borrow       <= 1'b0;
      borrow_out_r <= 1'b0;
      cnt          <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      // Result enters at the MSB so after WIDTH shifts bit 0 sits at d[0].
      d_r    <= {diff, d_r[WIDTH-1:1]};
      borrow <= bout;
      cnt    <= cnt + 1'b1;
      if (last) borrow_out_r <= bout;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand sign bits are kept from capture time since the shift registers
  // have shifted them down to bit 0 by the final cycle.
  logic a_msb;
  logic b_msb;
  logic ovf_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_r <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
      ovf_r <= 1'b0;
    end else if (state == ST_RUN && last) begin
      // diff on the final cycle is the result MSB.
      ovf_r <= (a_msb ^ b_msb) & (diff ^ a_msb);
    end
  end

  assign bus.ovf = ovf_r;
`endif

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.d          = d_r;
  assign bus.borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed scoreboard bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] held_d;
  logic         held_bo;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic [W-1:0] dv;
    dv   = av - bv;
    e.d  = dv;
    e.bo = (av < bv);
    e.ov = (av[W-1] != bv[W-1]) && (dv[W-1] != av[W-1]);
    return e;
  endfunction

  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input bit expect_result);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    if (expect_result) sb.push_back(model(av, bv));
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_d"}, 32'(bus.d), 32'(e.d));
      chk({tag, "_borrow"}, 32'(bus.borrow_out), 32'(e.bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ov));
`endif
      held_d  = e.d;
      held_bo = e.bo;
    end
  endtask

  // Entered with n samples already taken since the accepting edge, bn of them busy.
  task automatic wait_done(input string tag, input int n0, input int bn0);
    int n;
    int bn;
    n  = n0;
    bn = bn0;
    while (bus.done !== 1'b1 && n < 40) begin
      step();
      n++;
      if (bus.busy === 1'b1) bn++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd9);
    chk({tag, "_busy_cycles"}, 32'(bn), 32'd8);
    compare_result(tag);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    drive_start(av, bv, 1'b1);
    step();
    bus.start = 1'b0;
    chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    chk({tag, "_d_zero_run"}, 32'(bus.d), 32'd0);
    wait_done(tag, 1, (bus.busy === 1'b1) ? 1 : 0);
    step();
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_d_held"}, 32'(bus.d), 32'(held_d));
    chk({tag, "_bo_held"}, 32'(bus.borrow_out), 32'(held_bo));
  endtask

  initial begin
    int dones;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_d", 32'(bus.d), 32'd0);
    chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    reset = 1'b0;
    step();

    run_op("op35m12", 8'h35, 8'h12);
    step();
    chk("op35m12_d_held_idle", 32'(bus.d), 32'h23);
    run_op("op12m35", 8'h12, 8'h35);
    run_op("op00m01", 8'h00, 8'h01);
    run_op("opA5mA5", 8'hA5, 8'hA5);
    run_op("op80m01", 8'h80, 8'h01);
    run_op("op7FmFF", 8'h7F, 8'hFF);

    // start re-pulsed with new operands during RUN must be ignored
    drive_start(8'h35, 8'h12, 1'b1);
    step();
    bus.start = 1'b0;
    step();
    step();
    drive_start(8'hFF, 8'h0F, 1'b0);
    step();
    bus.start = 1'b0;
    wait_done("ignore_run_start", 4, 4);
    step();
    chk("ignore_no_restart_busy", 32'(bus.busy), 32'd0);
    chk("ignore_no_restart_d", 32'(bus.d), 32'h23);

    // start held high through DONE: second operation follows immediately
    step();
    drive_start(8'h35, 8'h12, 1'b1);
    step();
    bus.a = 8'h80;
    bus.b = 8'h01;
    wait_done("b2b_first", 1, 1);
    sb.push_back(model(8'h80, 8'h01));
    step();
    bus.start = 1'b0;
    chk("b2b_busy_again", 32'(bus.busy), 32'd1);
    chk("b2b_d_cleared", 32'(bus.d), 32'd0);
    wait_done("b2b_second", 1, 1);
    step();

    // reset in the middle of RUN
    drive_start(8'h55, 8'h22, 1'b0);
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_d", 32'(bus.d), 32'd0);
    chk("midrst_borrow", 32'(bus.borrow_out), 32'd0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.done === 1'b1) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
